// File: rtl/knn_batch_sched.sv
// Batch sequencer for the knn solver array: loads up to N_SOLVERS test points, broadcasts all
// training points, waits for the array, then drains HW_K neighbour labels per test point.
module knn_batch_sched #(
    parameter int N_SOLVERS = 4,
    parameter int HW_K      = 10,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int SOL_W     = (N_SOLVERS > 1) ? $clog2(N_SOLVERS) : 1,
    parameter int K_W       = (HW_K > 1) ? $clog2(HW_K) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_test,
    input  logic [ADDR_W-1:0] n_train,
    input  logic [ADDR_W-1:0] test_base,
    input  logic [ADDR_W-1:0] train_base,
    input  logic [ADDR_W-1:0] res_base,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dp_clr,
    output logic              dp_valid,
    output logic              dp_load,
    output logic [SOL_W-1:0]  dp_solver_sel,
    output logic [DATA_W-1:0] dp_data,
    input  logic              dp_done,
    output logic [K_W-1:0]    dp_sel,
    input  logic [DATA_W-1:0] dp_out,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_wdata
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] N_SOL_A  = ADDR_W'(N_SOLVERS);
    localparam logic [SOL_W-1:0]  SOL_ONE  = SOL_W'(1);
    localparam logic [K_W-1:0]    K_ONE    = K_W'(1);
    localparam logic [K_W-1:0]    K_LAST   = K_W'(HW_K - 1);

    typedef enum logic [2:0] {StIdle, StClr, StLoad, StTrain, StWait, StRead, StNext} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] n_test_q, n_train_q, test_base_q, train_base_q, res_base_q;
    logic [ADDR_W-1:0] t0_q, batch_q, cnt_q, remaining;
    logic              busy_q, done_q, mem_req_q, dp_clr_q, dp_valid_q, dp_load_q, res_we_q;
    logic [ADDR_W-1:0] mem_addr_q, res_addr_q;
    logic [SOL_W-1:0]  dp_solver_sel_q;
    logic [K_W-1:0]    dp_sel_q;

    assign remaining = n_test_q - t0_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= StIdle;
            n_test_q        <= '0;
            n_train_q       <= '0;
            test_base_q     <= '0;
            train_base_q    <= '0;
            res_base_q      <= '0;
            t0_q            <= '0;
            batch_q         <= '0;
            cnt_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
            dp_clr_q        <= 1'b0;
            dp_valid_q      <= 1'b0;
            dp_load_q       <= 1'b0;
            dp_solver_sel_q <= '0;
            dp_sel_q        <= '0;
            res_we_q        <= 1'b0;
            res_addr_q      <= '0;
        end else begin
            done_q   <= 1'b0;
            dp_clr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start landing on the done cycle belongs to the finished job.
                    if (start && !done_q) begin
                        if (n_test == '0 || n_train == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            n_test_q     <= n_test;
                            n_train_q    <= n_train;
                            test_base_q  <= test_base;
                            train_base_q <= train_base;
                            res_base_q   <= res_base;
                            t0_q         <= '0;
                            busy_q       <= 1'b1;
                            dp_clr_q     <= 1'b1;
                            state_q      <= StClr;
                        end
                    end
                end
                StClr: begin
                    batch_q    <= (remaining > N_SOL_A) ? N_SOL_A : remaining;
                    cnt_q      <= '0;
                    mem_req_q  <= 1'b1;
                    mem_addr_q <= test_base_q + t0_q;
                    state_q    <= StLoad;
                end
                StLoad: begin
                    if (mem_req_q) begin
                        dp_valid_q      <= 1'b1;
                        dp_load_q       <= 1'b1;
                        dp_solver_sel_q <= cnt_q[SOL_W-1:0];
                        if (cnt_q == batch_q - ADDR_ONE) begin
                            mem_req_q <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_q + ADDR_ONE;
                            mem_addr_q <= mem_addr_q + ADDR_ONE;
                        end
                    end else begin
                        dp_valid_q      <= 1'b0;
                        dp_load_q       <= 1'b0;
                        dp_solver_sel_q <= '0;
                        cnt_q           <= '0;
                        mem_req_q       <= 1'b1;
                        mem_addr_q      <= train_base_q;
                        state_q         <= StTrain;
                    end
                end
                StTrain: begin
                    if (mem_req_q) begin
                        dp_valid_q <= 1'b1;
                        if (cnt_q == n_train_q - ADDR_ONE) begin
                            mem_req_q <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_q + ADDR_ONE;
                            mem_addr_q <= mem_addr_q + ADDR_ONE;
                        end
                    end else begin
                        dp_valid_q <= 1'b0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (dp_done) begin
                        res_we_q        <= 1'b1;
                        cnt_q           <= '0;
                        dp_solver_sel_q <= '0;
                        dp_sel_q        <= '0;
                        // Result blocks of successive batches are contiguous.
                        res_addr_q      <= (t0_q == '0) ? res_base_q : res_addr_q + ADDR_ONE;
                        state_q         <= StRead;
                    end
                end
                StRead: begin
                    if (dp_sel_q != K_LAST) begin
                        dp_sel_q   <= dp_sel_q + K_ONE;
                        res_addr_q <= res_addr_q + ADDR_ONE;
                    end else if (cnt_q != batch_q - ADDR_ONE) begin
                        cnt_q           <= cnt_q + ADDR_ONE;
                        dp_solver_sel_q <= dp_solver_sel_q + SOL_ONE;
                        dp_sel_q        <= '0;
                        res_addr_q      <= res_addr_q + ADDR_ONE;
                    end else begin
                        res_we_q        <= 1'b0;
                        dp_sel_q        <= '0;
                        dp_solver_sel_q <= '0;
                        t0_q            <= t0_q + batch_q;
                        state_q         <= StNext;
                    end
                end
                StNext: begin
                    if (t0_q < n_test_q) begin
                        dp_clr_q <= 1'b1;
                        state_q  <= StClr;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign dp_clr        = dp_clr_q;
    assign dp_valid      = dp_valid_q;
    assign dp_load       = dp_load_q;
    assign dp_solver_sel = dp_solver_sel_q;
    assign dp_sel        = dp_sel_q;
    assign res_we        = res_we_q;
    assign res_addr      = res_addr_q;
    // Gated so both data outputs drop to zero immediately on reset.
    assign dp_data       = dp_valid_q ? mem_rdata : '0;
    assign res_wdata     = res_we_q ? dp_out : '0;

endmodule

// File: tb/tb_knn_batch_sched.sv
// Scoreboard bench for knn_batch_sched: jobs push expected memory reads, datapath strobes and
// result writes; a negedge monitor pops and compares them as the DUT produces them.
module tb_knn_batch_sched;

    localparam int N_SOLVERS = 4;
    localparam int HW_K      = 10;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int SOL_W     = 2;
    localparam int K_W       = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] n_test = '0, n_train = '0, test_base = '0, train_base = '0, res_base = '0;
    logic              busy, done, mem_req, dp_clr, dp_valid, dp_load, res_we;
    logic [ADDR_W-1:0] mem_addr, res_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] dp_data, dp_out, res_wdata;
    logic [SOL_W-1:0]  dp_solver_sel;
    logic [K_W-1:0]    dp_sel;
    logic              dp_done = 1'b0;

    knn_batch_sched #(
        .N_SOLVERS(N_SOLVERS), .HW_K(HW_K), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .SOL_W(SOL_W), .K_W(K_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_test(n_test), .n_train(n_train),
        .test_base(test_base), .train_base(train_base), .res_base(res_base),
        .busy(busy), .done(done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dp_clr(dp_clr), .dp_valid(dp_valid), .dp_load(dp_load), .dp_solver_sel(dp_solver_sel),
        .dp_data(dp_data), .dp_done(dp_done), .dp_sel(dp_sel), .dp_out(dp_out),
        .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    function automatic logic [31:0] label(input logic [1:0] s, input logic [3:0] k);
        return {16'hC0DE, 6'h0, s, 4'h0, k};
    endfunction

    // Point memory: one-cycle read latency; poison when not requested.
    always @(posedge clk) mem_rdata <= mem_req ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    assign dp_out = label(dp_solver_sel, dp_sel);

    // Solver array model: done wait_lat cycles after all broadcasts, cleared by dp_clr.
    int cur_n_train = 0, wait_lat = 0, bc = 0, lat_cnt = 0;
    always @(posedge clk) begin
        if (!rst || dp_clr) begin
            dp_done <= 1'b0;
            bc      <= 0;
            lat_cnt <= 0;
        end else if (dp_valid && !dp_load) begin
            bc <= bc + 1;
        end else if (bc == cur_n_train && !dp_done) begin
            if (lat_cnt >= wait_lat) dp_done <= 1'b1;
            else lat_cnt <= lat_cnt + 1;
        end
    end

    typedef struct packed {logic ld; logic [1:0] sel; logic [31:0] data;} dp_ev_t;
    typedef struct packed {logic [15:0] addr; logic [31:0] data;} res_ev_t;
    logic [15:0] exp_mem[$];
    dp_ev_t      exp_dp[$];
    res_ev_t     exp_res[$];
    int n_checks = 0, n_fail = 0, clr_seen = 0, done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor
    int      mcyc = 0, dpd_rise = -100;
    logic    dpd_prev = 1'b0, rw_prev = 1'b0;
    dp_ev_t  mdp;
    res_ev_t mres;
    initial begin
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst) begin
                if (dp_done && !dpd_prev) dpd_rise = mcyc;
                if (res_we && !rw_prev) check("readout_latency", 64'(mcyc - dpd_rise), 64'd1);
                if (mem_req) begin
                    if (exp_mem.size() == 0) check("mem_req_unexpected", mem_req, 0);
                    else check("mem_addr", mem_addr, exp_mem.pop_front());
                end
                if (dp_valid) begin
                    if (exp_dp.size() == 0) begin
                        check("dp_valid_unexpected", dp_valid, 0);
                    end else begin
                        mdp = exp_dp.pop_front();
                        check("dp_load", dp_load, mdp.ld);
                        if (mdp.ld) check("dp_solver_sel", dp_solver_sel, mdp.sel);
                        check("dp_data", dp_data, mdp.data);
                    end
                end
                if (res_we) begin
                    if (exp_res.size() == 0) begin
                        check("res_we_unexpected", res_we, 0);
                    end else begin
                        mres = exp_res.pop_front();
                        check("res_addr", res_addr, mres.addr);
                        check("res_wdata", res_wdata, mres.data);
                    end
                end
                if (dp_clr) clr_seen++;
                if (done) done_seen++;
            end
            dpd_prev = dp_done;
            rw_prev  = res_we;
        end
    end

    task automatic push_job(input int nt, input int ntr, input logic [15:0] a_test,
                            input logic [15:0] a_train, input logic [15:0] a_res);
        int t0, b;
        t0 = 0;
        while (t0 < nt) begin
            b = (nt - t0 > N_SOLVERS) ? N_SOLVERS : nt - t0;
            for (int i = 0; i < b; i++) begin
                exp_mem.push_back(16'(a_test + t0 + i));
                exp_dp.push_back('{1'b1, 2'(i), mem_word(16'(a_test + t0 + i))});
            end
            for (int j = 0; j < ntr; j++) begin
                exp_mem.push_back(16'(a_train + j));
                exp_dp.push_back('{1'b0, 2'b0, mem_word(16'(a_train + j))});
            end
            for (int s = 0; s < b; s++)
                for (int k = 0; k < HW_K; k++)
                    exp_res.push_back('{16'(a_res + (t0 + s) * HW_K + k), label(2'(s), 4'(k))});
            t0 += b;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {busy, done, mem_req, dp_clr, dp_valid, dp_load, res_we}, 0);
        check({tag, "_addr"}, {mem_addr, res_addr, dp_solver_sel, dp_sel}, 0);
        check({tag, "_data"}, {dp_data, res_wdata}, 0);
    endtask

    task automatic run_job(input string tag, input int nt, input int ntr, input logic [15:0] a_test,
                           input logic [15:0] a_train, input logic [15:0] a_res, input int lat,
                           input int batches, input bit repulse);
        int clr0, done0, cyc;
        cur_n_train = ntr;
        wait_lat    = lat;
        push_job(nt, ntr, a_test, a_train, a_res);
        clr0  = clr_seen;
        done0 = done_seen;
        n_test = 16'(nt); n_train = 16'(ntr);
        test_base = a_test; train_base = a_train; res_base = a_res;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        // Config changes while busy must not matter.
        n_test = 16'd1; n_train = 16'd1; test_base = 16'h7777; train_base = 16'h8888;
        res_base = 16'h9999;
        if (repulse) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        repeat (3) @(negedge clk);
        check({tag, "_mem_left"}, exp_mem.size(), 0);
        check({tag, "_dp_left"}, exp_dp.size(), 0);
        check({tag, "_res_left"}, exp_res.size(), 0);
        check({tag, "_clr_count"}, clr_seen - clr0, batches);
        check({tag, "_done_count"}, done_seen - done0, 1);
    endtask

    task automatic zero_job(input string tag, input int nt, input int ntr);
        int done0;
        done0 = done_seen;
        n_test = 16'(nt); n_train = 16'(ntr);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        // A valid start in the done cycle must be ignored.
        n_test = 16'd2; n_train = 16'd2;
        @(negedge clk) start = 1'b0;
        check({tag, "_done_pulse"}, {done, busy}, 0);
        repeat (3) @(negedge clk);
        check({tag, "_idle_after"}, busy, 0);
        check({tag, "_done_count"}, done_seen - done0, 1);
    endtask

    initial begin
        int cyc, done0;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_job("single", 3, 5, 16'h0100, 16'h0200, 16'h1000, 2, 1, 1'b0);
        run_job("two_batch", 6, 4, 16'h0300, 16'h0400, 16'h2000, 0, 2, 1'b0);
        zero_job("zero_test", 0, 5);
        zero_job("zero_train", 4, 0);
        run_job("slow_done", 2, 3, 16'h0500, 16'h0600, 16'h3000, 50, 1, 1'b0);

        // Asynchronous reset in the middle of the training broadcast.
        cur_n_train = 20;
        wait_lat    = 0;
        push_job(2, 20, 16'h0700, 16'h0800, 16'h4000);
        done0 = done_seen;
        n_test = 16'd2; n_train = 16'd20; test_base = 16'h0700; train_base = 16'h0800;
        res_base = 16'h4000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (!(dp_valid && !dp_load) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_train", {dp_valid, dp_load}, 2'b10);
        #2 rst = 1'b0;
        #1 check_outputs_zero("mid_reset");
        exp_mem.delete();
        exp_dp.delete();
        exp_res.delete();
        repeat (3) @(negedge clk);
        check("mid_reset_no_done", done_seen - done0, 0);
        rst = 1'b1;
        @(negedge clk);
        run_job("after_reset", 5, 3, 16'h0900, 16'h0A00, 16'h5000, 1, 2, 1'b0);

        run_job("wrap_repulse", 2, 3, 16'hFFFF, 16'hFFFE, 16'hFFFE, 1, 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
